// File: rtl/btn_press_classifier.sv
// ---------------------------------------------------------------------------
// btn_press_classifier
//
// Classifies a debounced push-button level into short, double, long and
// auto-repeat press events. One FSM and one 8-bit tick counter run on a
// 200 Hz tick clock. Every event output is a registered one-cycle pulse.
//
// Counting convention: cnt is cleared on entry to a state. Each later sample
// taken in that state with the "continuing" level advances it. A timeout
// fires on the sample that sees cnt == TICKS-1, so a state times out on its
// TICKS-th sample after the entry edge.
//
// Parameters
//   LONG_TICKS    hold length (ticks) that makes a press long     (2..255)
//   DBL_GAP_TICKS longest release gap (ticks) for a double press  (2..255)
//   REPEAT_TICKS  auto-repeat period (ticks) after a long press   (2..255)
//
// Ports
//   clk_5ms       in   200 Hz tick clock, rising edge active
//   rst           in   asynchronous, active-high reset
//   btn_deb       in   debounced button level, 1 = pressed
//   short_press   out  one-cycle pulse: single short press
//   double_press  out  one-cycle pulse: double press
//   long_press    out  one-cycle pulse: hold reached LONG_TICKS
//   repeat_press  out  one-cycle pulse every REPEAT_TICKS after long_press
//   state_dbg     out  registered FSM state (IDLE=0 PRESS1=1 WAIT2=2
//                      PRESS2=3 HOLD=4)
// ---------------------------------------------------------------------------
module btn_press_classifier #(
  parameter int LONG_TICKS    = 200,
  parameter int DBL_GAP_TICKS = 60,
  parameter int REPEAT_TICKS  = 40
) (
  input  logic       clk_5ms,
  input  logic       rst,
  input  logic       btn_deb,
  output logic       short_press,
  output logic       double_press,
  output logic       long_press,
  output logic       repeat_press,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HOLD   = 3'd4
  } state_t;

  // Terminal counts. All are at most 254, so no increment path can wrap.
  localparam logic [7:0] LONG_LAST   = 8'(LONG_TICKS - 1);
  localparam logic [7:0] GAP_LAST    = 8'(DBL_GAP_TICKS - 1);
  localparam logic [7:0] REPEAT_LAST = 8'(REPEAT_TICKS - 1);

  state_t     state;
  logic [7:0] cnt;

  // The state register is itself the debug output.
  assign state_dbg = state;

  // Press classifier FSM, tick counter and registered event pulses.
  always_ff @(posedge clk_5ms or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      short_press  <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
      repeat_press <= 1'b0;
    end else begin
      // Each pulse is raised for exactly one cycle. At most one branch
      // below sets a pulse, so at most one pulse is high in any cycle.
      short_press  <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
      repeat_press <= 1'b0;

      case (state)
        IDLE: begin
          if (btn_deb) begin
            state <= PRESS1;
            cnt   <= 8'd0;
          end else begin
            state <= IDLE;
          end
        end

        PRESS1: begin
          if (btn_deb) begin
            if (cnt == LONG_LAST) begin
              long_press <= 1'b1;
              state      <= HOLD;
              cnt        <= 8'd0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end else begin
            state <= WAIT2;
            cnt   <= 8'd0;
          end
        end

        WAIT2: begin
          // A new press wins over the gap timeout, even on the last gap tick.
          if (btn_deb) begin
            state <= PRESS2;
            cnt   <= 8'd0;
          end else if (cnt == GAP_LAST) begin
            short_press <= 1'b1;
            state       <= IDLE;
            cnt         <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        PRESS2: begin
          // The second press of a double has no time limit. cnt stays at 0.
          cnt <= 8'd0;
          if (btn_deb) begin
            state <= PRESS2;
          end else begin
            double_press <= 1'b1;
            state        <= IDLE;
          end
        end

        HOLD: begin
          if (btn_deb) begin
            if (cnt == REPEAT_LAST) begin
              repeat_press <= 1'b1;
              cnt          <= 8'd0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end else begin
            state <= IDLE;
            cnt   <= 8'd0;
          end
        end

        default: begin
          // Encodings 5..7 are unreachable. Recover quietly to IDLE.
          state <= IDLE;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_press_classifier.sv
// ---------------------------------------------------------------------------
// tb_btn_press_classifier
//
// Self-checking bench for btn_press_classifier with its default parameters.
//
// Edge k is the first rising edge that samples btn_deb = 1 from IDLE. Every
// expected pulse is written as (kind, edge index). The bench pushes it into a
// scoreboard queue when the stimulus starts. A monitor samples 1 time unit
// after each rising edge. Whenever a pulse is high, the monitor pops the
// oldest expectation and compares the pulse kind and the edge it belongs to.
//
// Kinds: 1 = short, 2 = double, 3 = long, 4 = repeat.
// ---------------------------------------------------------------------------
module tb_btn_press_classifier;

  logic       clk_5ms;
  logic       rst;
  logic       btn_deb;
  logic       short_press;
  logic       double_press;
  logic       long_press;
  logic       repeat_press;
  logic [2:0] state_dbg;

  btn_press_classifier dut (
    .clk_5ms      (clk_5ms),
    .rst          (rst),
    .btn_deb      (btn_deb),
    .short_press  (short_press),
    .double_press (double_press),
    .long_press   (long_press),
    .repeat_press (repeat_press),
    .state_dbg    (state_dbg)
  );

  initial begin
    clk_5ms = 1'b0;
    forever #5 clk_5ms = ~clk_5ms;
  end

  // Index of the most recent rising edge. The first edge has index 1.
  int edge_n = 0;
  always @(posedge clk_5ms) edge_n <= edge_n + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int kind;
    int at;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edge_n);
    end
  endtask

  task automatic push(input int kind, input int at);
    exp_t e;
    if (kind != 0) begin
      e.kind = kind;
      e.at   = at;
      exp_q.push_back(e);
    end
  endtask

  // Scoreboard monitor: match every observed pulse against the queue.
  always begin
    int   n_hi;
    int   kind;
    exp_t e;
    @(posedge clk_5ms);
    #1;
    n_hi = int'(short_press) + int'(double_press) + int'(long_press) + int'(repeat_press);
    kind = short_press ? 1 : double_press ? 2 : long_press ? 3 : repeat_press ? 4 : 0;
    if (n_hi > 1) begin
      chk("pulse_onehot", n_hi, 1);
    end else if (n_hi == 1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse_kind", kind, 0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind", kind, e.kind);
        chk("pulse_edge", edge_n, e.at);
      end
    end
  end

  // Sets btn_deb before each of the next n rising edges.
  task automatic drive(input logic level, input int n);
    repeat (n) begin
      @(negedge clk_5ms);
      btn_deb = level;
    end
  endtask

  // Starts a press. The returned k is the edge that first samples it.
  task automatic start_press(output int k);
    @(negedge clk_5ms);
    k       = edge_n + 1;
    btn_deb = 1'b1;
  endtask

  // Samples state_dbg just after the next rising edge.
  task automatic chk_state_next(input string name, input int req);
    @(posedge clk_5ms);
    #2;
    chk(name, int'(state_dbg), req);
  endtask

  // Each vector: h1 high samples from edge k, then gap low samples, then h2
  // high samples (skipped if 0), then a long low tail. Up to three pulses
  // are expected, each given as (kind, offset from k).
  typedef struct {
    string name;
    int    h1;
    int    gap;
    int    h2;
    int    k0, o0, k1, o1, k2, o2;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int k;
    start_press(k);
    push(v.k0, k + v.o0);
    push(v.k1, k + v.o1);
    push(v.k2, k + v.o2);
    drive(1'b1, v.h1 - 1);
    drive(1'b0, v.gap);
    if (v.h2 > 0) drive(1'b1, v.h2);
    drive(1'b0, 80);
    chk({v.name, "_drained"}, exp_q.size(), 0);
    chk({v.name, "_idle"}, int'(state_dbg), 0);
  endtask

  vec_t vecs[7];

  initial begin
    int k;

    // Short press: release at k+10, gap timeout after edge k+70.
    vecs[0] = '{"short",       10,  0,  0, 1,  70, 0,   0, 0,   0};
    // Double press: second press k+30..k+39, released at k+40.
    vecs[1] = '{"double",      10, 20, 10, 2,  40, 0,   0, 0,   0};
    // Long press and auto-repeat, held through edge k+300.
    vecs[2] = '{"long_rep",   301,  0,  0, 3, 200, 4, 240, 4, 280};
    // Gap boundary. Low k+10..k+69: the last gap tick is reached, but the
    // press at k+70 still wins, so this is a double press.
    vecs[3] = '{"gap_59",      10, 60,  5, 2,  75, 0,   0, 0,   0};
    // Gap boundary. Low k+10..k+70: short press after edge k+70. The press
    // at k+71 starts a new press from IDLE and ends as a short at k+136.
    vecs[4] = '{"gap_60",      10, 61,  5, 1,  70, 1, 136, 0,   0};
    // Long boundary. Released on edge k+200 (cnt=199, level low): short.
    vecs[5] = '{"hold_199",   200,  0,  0, 1, 260, 0,   0, 0,   0};
    // Long boundary. Still high on edge k+200: long_press.
    vecs[6] = '{"hold_200",   201,  0,  0, 3, 200, 0,   0, 0,   0};

    rst     = 1'b1;
    btn_deb = 1'b0;
    repeat (3) @(posedge clk_5ms);
    #2;
    chk("rst_state",  int'(state_dbg),    0);
    chk("rst_short",  int'(short_press),  0);
    chk("rst_double", int'(double_press), 0);
    chk("rst_long",   int'(long_press),   0);
    chk("rst_repeat", int'(repeat_press), 0);
    @(negedge clk_5ms);
    rst = 1'b0;
    drive(1'b0, 3);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // State trace of a short press: WAIT2 after edge k+10, IDLE after k+70.
    start_press(k);
    push(1, k + 70);
    drive(1'b1, 9);
    drive(1'b0, 1);
    chk_state_next("short_wait2", 2);
    while (edge_n < k + 69) @(posedge clk_5ms);
    chk_state_next("short_idle", 0);
    drive(1'b0, 10);
    chk("short_trace_drained", exp_q.size(), 0);

    // Third press on the edge right after the double_press pulse.
    start_press(k);
    push(2, k + 40);
    push(1, k + 111);
    drive(1'b1, 9);
    drive(1'b0, 20);
    drive(1'b1, 10);
    drive(1'b0, 1);
    drive(1'b1, 1);
    chk_state_next("third_press1", 1);
    drive(1'b1, 9);
    drive(1'b0, 80);
    chk("third_drained", exp_q.size(), 0);

    // Reset in HOLD after edge k+250 while the button stays pressed.
    start_press(k);
    push(3, k + 200);
    push(4, k + 240);
    drive(1'b1, 250);
    @(posedge clk_5ms);
    #2;
    rst = 1'b1;
    #1;
    chk("hold_rst_state",  int'(state_dbg),    0);
    chk("hold_rst_pulses", int'(short_press) + int'(double_press) +
                           int'(long_press) + int'(repeat_press), 0);
    chk("hold_rst_drained", exp_q.size(), 0);
    // rst is released with btn_deb still high. The next edge is a fresh k.
    @(negedge clk_5ms);
    rst = 1'b0;
    k   = edge_n + 1;
    push(1, k + 110);
    chk_state_next("after_rst_press1", 1);
    drive(1'b1, 49);
    drive(1'b0, 80);
    chk("after_rst_drained", exp_q.size(), 0);
    chk("after_rst_idle", int'(state_dbg), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/btn_press_classifier.md
BTN_PRESS_CLASSIFIER -- requirements
Module: btn_press_classifier

Interface
REQ-001 Parameter LONG_TICKS, default 200, hold duration in clk_5ms cycles (1 s) that classifies a press as long; legal range 2..255.
REQ-002 Parameter DBL_GAP_TICKS, default 60, maximum release-to-press gap in cycles (300 ms) for a double press; legal range 2..255.
REQ-003 Parameter REPEAT_TICKS, default 40, auto-repeat period in cycles (200 ms) while held after a long press; legal range 2..255.
REQ-004 clk_5ms  input  1  200 Hz tick clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 btn_deb  input  1  debounced button level, already synchronous to clk_5ms; 1 = pressed.
REQ-007 short_press  output  1  one-cycle pulse: single short press classified.
REQ-008 double_press  output  1  one-cycle pulse: double press classified.
REQ-009 long_press  output  1  one-cycle pulse: hold reached LONG_TICKS.
REQ-010 repeat_press  output  1  one-cycle pulse every REPEAT_TICKS while held after long_press.
REQ-011 state_dbg  output  3  current FSM state encoding: IDLE=0, PRESS1=1, WAIT2=2, PRESS2=3, HOLD=4.

Function
REQ-012 Single FSM (IDLE, PRESS1, WAIT2, PRESS2, HOLD) plus one 8-bit tick counter cnt; all outputs registered.
REQ-013 Edge k = first rising edge at which btn_deb is sampled 1 while in IDLE; at edge k: state->PRESS1, cnt->0.
REQ-014 PRESS1, btn_deb=1: if cnt==LONG_TICKS-1 -> long_press=1 for next cycle, state->HOLD, cnt->0; else cnt+1.
REQ-015 PRESS1, btn_deb=0: state->WAIT2, cnt->0, no pulse.
REQ-016 WAIT2, btn_deb=1: state->PRESS2, cnt->0.
REQ-017 WAIT2, btn_deb=0: if cnt==DBL_GAP_TICKS-1 -> short_press=1 next cycle, state->IDLE; else cnt+1.
REQ-018 PRESS2: stays while btn_deb=1 with no timeout (cnt held at 0); on btn_deb=0 -> double_press=1 next cycle, state->IDLE.
REQ-019 HOLD, btn_deb=1: if cnt==REPEAT_TICKS-1 -> repeat_press=1 next cycle, cnt->0; else cnt+1.
REQ-020 HOLD, btn_deb=0: state->IDLE, cnt->0, no pulse.
REQ-021 Every pulse output is high for exactly one clk_5ms cycle; at most one pulse output high in any cycle.
REQ-022 IDLE with btn_deb=0: no change; cnt never wraps (every increment path is bounded by a compare below 255).
REQ-023 A third press after double_press is treated as a fresh edge k from IDLE (earliest: edge following double_press).
REQ-024 state_dbg reflects the registered state; illegal encodings 5..7 return to IDLE on next edge with no pulse.
REQ-025 A press held through LONG_TICKS never yields short_press or double_press for that press.

Reset
REQ-026 rst=1 asynchronously forces state=IDLE, cnt=0, short_press=double_press=long_press=repeat_press=0, state_dbg=0.
REQ-027 Reset mid-sequence (any state) discards the sequence; no pulse emitted on or after release of rst for it.
REQ-028 After rst deasserts with btn_deb already 1, first edge sampling 1 counts as edge k (press starts then).

Verification
REQ-029 Short press, defaults: btn_deb high edges k..k+9, low from k+10 -> short_press single pulse after edge k+70, state_dbg 2 then 0.
REQ-030 Double press: high k..k+9, low k+10..k+29, high k+30..k+39, low k+40 -> double_press pulse after edge k+40, no short_press.
REQ-031 Long + repeat: held k..k+300 -> long_press after edge k+200, repeat_press after edges k+240 and k+280, release -> IDLE, no other pulse.
REQ-032 Gap boundary: release gap of 59 low samples -> double_press; gap of 60 low samples -> short_press after 60th low sample, then new press starts in IDLE.
REQ-033 Reset mid-HOLD at edge k+250: all outputs 0 immediately, state_dbg=0, no repeat_press until a new press exceeds LONG_TICKS.
REQ-034 Long threshold boundary: held for exactly 199 samples then released -> no long_press, short_press after gap timeout; held 200 samples -> long_press.
